// File: rtl/csr_trap_sequencer_pkg.sv
// CSR addresses, field positions and FSM state encodings for the trap sequencer.
package csr_trap_sequencer_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00c;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;

    localparam int CRMD_PLV_LSB    = 0;
    localparam int CRMD_IE         = 2;
    localparam int PRMD_PPLV_LSB   = 0;
    localparam int PRMD_PIE        = 2;
    localparam int ESTAT_ECODE_LSB = 16;
    localparam int ESTAT_ESUB_LSB  = 22;
    localparam int EENTRY_ALIGN    = 6;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_X_RD_CRMD  = 4'd1;
    localparam logic [3:0] S_X_WR_PRMD  = 4'd2;
    localparam logic [3:0] S_X_WR_CRMD  = 4'd3;
    localparam logic [3:0] S_X_WR_ERA   = 4'd4;
    localparam logic [3:0] S_X_WR_ESTAT = 4'd5;
    localparam logic [3:0] S_X_WR_BADV  = 4'd6;
    localparam logic [3:0] S_X_REDIR    = 4'd7;
    localparam logic [3:0] S_R_RD_PRMD  = 4'd8;
    localparam logic [3:0] S_R_RD_CRMD  = 4'd9;
    localparam logic [3:0] S_R_WR_CRMD  = 4'd10;
    localparam logic [3:0] S_R_REDIR    = 4'd11;

endpackage

// File: rtl/csr_trap_sequencer.sv
// Arbitrates the CSR file ports between pipeline csrrd/csrwr and the trap entry / ERTN sequences.
// Handshake: a csrwr is taken in the cycle pipe_wr_valid && pipe_wr_ready; nothing is held over.
module csr_trap_sequencer
    import csr_trap_sequencer_pkg::*;
#(
    parameter int CSR_AW  = 14,
    parameter int XLEN    = 32,
    parameter int ECODE_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                excp_valid,
    input  logic [ECODE_W-1:0]  excp_ecode,
    input  logic [8:0]          excp_esubcode,
    input  logic [XLEN-1:0]     excp_pc,
    input  logic [XLEN-1:0]     excp_badv,
    input  logic                excp_badv_vld,
    input  logic                ertn_valid,
    input  logic                pipe_wr_valid,
    output logic                pipe_wr_ready,
    input  logic [CSR_AW-1:0]   pipe_waddr,
    input  logic [XLEN-1:0]     pipe_wdata,
    input  logic [CSR_AW-1:0]   pipe_raddr,
    output logic [XLEN-1:0]     pipe_rdata,
    output logic                csr_wr_en,
    output logic [CSR_AW-1:0]   csr_waddr,
    output logic [XLEN-1:0]     csr_wdata,
    output logic [CSR_AW-1:0]   csr_raddr,
    input  logic [XLEN-1:0]     csr_rdata,
    output logic                busy,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc,
    output logic [3:0]          dbg_state
);

    logic [3:0]         state_q, state_d;
    logic [ECODE_W-1:0] ecode_q;
    logic [8:0]         esub_q;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    badv_q;
    logic               badv_vld_q;
    logic [XLEN-1:0]    crmd_q;
    logic [2:0]         prmd_q;
    logic               estat_top_q;
    logic [15:0]        estat_low_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ecode_q     <= '0;
            esub_q      <= '0;
            pc_q        <= '0;
            badv_q      <= '0;
            badv_vld_q  <= 1'b0;
            crmd_q      <= '0;
            prmd_q      <= '0;
            estat_top_q <= 1'b0;
            estat_low_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && excp_valid) begin
                ecode_q    <= excp_ecode;
                esub_q     <= excp_esubcode;
                pc_q       <= excp_pc;
                badv_q     <= excp_badv;
                badv_vld_q <= excp_badv_vld;
            end
            if (state_q == S_X_RD_CRMD || state_q == S_R_RD_CRMD) begin
                crmd_q <= csr_rdata;
            end
            if (state_q == S_R_RD_PRMD) begin
                prmd_q <= csr_rdata[2:0];
            end
            if (state_q == S_X_WR_ERA) begin
                estat_top_q <= csr_rdata[XLEN-1];
                estat_low_q <= csr_rdata[15:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        csr_raddr      = pipe_raddr;
        csr_wr_en      = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        pipe_wr_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                pipe_wr_ready = ~excp_valid & ~ertn_valid;
                if (excp_valid) begin
                    state_d = S_X_RD_CRMD;
                end else if (ertn_valid) begin
                    state_d = S_R_RD_PRMD;
                end else if (pipe_wr_valid) begin
                    csr_wr_en = 1'b1;
                    csr_waddr = pipe_waddr;
                    csr_wdata = pipe_wdata;
                end
            end
            S_X_RD_CRMD: begin
                csr_raddr = CSR_AW'(CSR_CRMD);
                state_d   = S_X_WR_PRMD;
            end
            S_X_WR_PRMD: begin
                csr_wr_en = 1'b1;
                csr_waddr = CSR_AW'(CSR_PRMD);
                csr_wdata = {{(XLEN-3){1'b0}}, crmd_q[CRMD_IE], crmd_q[CRMD_PLV_LSB+:2]};
                state_d   = S_X_WR_CRMD;
            end
            S_X_WR_CRMD: begin
                csr_wr_en = 1'b1;
                csr_waddr = CSR_AW'(CSR_CRMD);
                csr_wdata = {crmd_q[XLEN-1:3], 3'b000};
                state_d   = S_X_WR_ERA;
            end
            S_X_WR_ERA: begin
                csr_wr_en = 1'b1;
                csr_waddr = CSR_AW'(CSR_ERA);
                csr_wdata = pc_q;
                csr_raddr = CSR_AW'(CSR_ESTAT);
                state_d   = S_X_WR_ESTAT;
            end
            S_X_WR_ESTAT: begin
                csr_wr_en = 1'b1;
                csr_waddr = CSR_AW'(CSR_ESTAT);
                csr_wdata = {estat_top_q, esub_q, ecode_q, estat_low_q};
                state_d   = badv_vld_q ? S_X_WR_BADV : S_X_REDIR;
            end
            S_X_WR_BADV: begin
                csr_wr_en = 1'b1;
                csr_waddr = CSR_AW'(CSR_BADV);
                csr_wdata = badv_q;
                state_d   = S_X_REDIR;
            end
            S_X_REDIR: begin
                csr_raddr      = CSR_AW'(CSR_EENTRY);
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rdata[XLEN-1:EENTRY_ALIGN], {EENTRY_ALIGN{1'b0}}};
                state_d        = S_IDLE;
            end
            S_R_RD_PRMD: begin
                csr_raddr = CSR_AW'(CSR_PRMD);
                state_d   = S_R_RD_CRMD;
            end
            S_R_RD_CRMD: begin
                csr_raddr = CSR_AW'(CSR_CRMD);
                state_d   = S_R_WR_CRMD;
            end
            S_R_WR_CRMD: begin
                csr_wr_en = 1'b1;
                csr_waddr = CSR_AW'(CSR_CRMD);
                csr_wdata = {crmd_q[XLEN-1:3], prmd_q[PRMD_PIE], prmd_q[PRMD_PPLV_LSB+:2]};
                state_d   = S_R_REDIR;
            end
            S_R_REDIR: begin
                csr_raddr      = CSR_AW'(CSR_ERA);
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A cycle with reset low abandons everything: no write or redirect escapes.
        if (!reset) begin
            csr_wr_en      = 1'b0;
            redirect_valid = 1'b0;
            pipe_wr_ready  = 1'b0;
        end
    end

    assign pipe_rdata = csr_rdata;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

    a_no_req_while_busy: assert property (@(posedge clk) disable iff (!reset)
        busy |-> !(excp_valid || ertn_valid));

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench: CSR file model, expected-write scoreboard, trap/ERTN/arbitration/reset vectors.
module tb_csr_trap_sequencer;
    import csr_trap_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        excp_valid = 1'b0;
    logic [5:0]  excp_ecode = '0;
    logic [8:0]  excp_esubcode = '0;
    logic [31:0] excp_pc = '0;
    logic [31:0] excp_badv = '0;
    logic        excp_badv_vld = 1'b0;
    logic        ertn_valid = 1'b0;
    logic        pipe_wr_valid = 1'b0;
    logic        pipe_wr_ready;
    logic [13:0] pipe_waddr = '0;
    logic [31:0] pipe_wdata = '0;
    logic [13:0] pipe_raddr = '0;
    logic [31:0] pipe_rdata;
    logic        csr_wr_en;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc;
    int redir_seen;
    logic [45:0] exp_q[$];

    logic [31:0] csr_mem [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    csr_trap_sequencer dut (
        .clk(clk), .reset(reset),
        .excp_valid(excp_valid), .excp_ecode(excp_ecode), .excp_esubcode(excp_esubcode),
        .excp_pc(excp_pc), .excp_badv(excp_badv), .excp_badv_vld(excp_badv_vld),
        .ertn_valid(ertn_valid),
        .pipe_wr_valid(pipe_wr_valid), .pipe_wr_ready(pipe_wr_ready),
        .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .pipe_raddr(pipe_raddr), .pipe_rdata(pipe_rdata),
        .csr_wr_en(csr_wr_en), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dbg_state(dbg_state)
    );

    // clock / reset-independent infrastructure
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // CSR file model: combinational read, write at posedge
    assign csr_rdata = csr_mem[csr_raddr];
    always @(posedge clk) begin
        if (csr_wr_en) csr_mem[csr_waddr] <= csr_wdata;
        if (pl_en) csr_mem[pl_addr] <= pl_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard: every CSR write must match the head of exp_q
    always @(negedge clk) begin
        if (csr_wr_en) begin
            if (exp_q.size() == 0) check("spurious_wr", 64'({csr_waddr, csr_wdata}), 64'(0));
            else check("csr_wr", 64'({csr_waddr, csr_wdata}), 64'(exp_q.pop_front()));
        end
        if (redirect_valid) redir_seen++;
    end

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic expect_wr(input logic [13:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // called right after the accept posedge (+1); returns cycle index of redirect
    task automatic wait_redirect(output int c);
        c = 1;
        forever begin
            @(negedge clk);
            if (redirect_valid || c >= 20) break;
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic drive_trap(input logic [5:0] ec, input logic [8:0] es, input logic [31:0] pc,
                              input logic [31:0] bv, input logic bvld, input logic combo);
        @(posedge clk); #1;
        excp_valid = 1'b1; excp_ecode = ec; excp_esubcode = es;
        excp_pc = pc; excp_badv = bv; excp_badv_vld = bvld;
        if (combo) begin
            ertn_valid = 1'b1; pipe_wr_valid = 1'b1;
            pipe_waddr = CSR_SAVE0; pipe_wdata = 32'h1111_1111;
        end
        @(negedge clk);
        check("accept_ready", 64'(pipe_wr_ready), 64'(0));
        check("accept_wr_en", 64'(csr_wr_en), 64'(0));
        @(posedge clk); #1;
        excp_valid = 1'b0; ertn_valid = 1'b0;
    endtask

    initial begin
        // reset, with a csrwr request pending that must be suppressed
        pipe_wr_valid = 1'b1; pipe_waddr = CSR_SAVE0; pipe_wdata = 32'h5555_5555;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_redir", 64'(redirect_valid), 64'(0));
        check("rst_wr_en", 64'(csr_wr_en), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        pipe_wr_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // csrwr SAVE0 in IDLE: zero-latency write
        expect_wr(CSR_SAVE0, 32'hdead_beef);
        @(posedge clk); #1;
        pipe_wr_valid = 1'b1; pipe_waddr = CSR_SAVE0; pipe_wdata = 32'hdead_beef;
        @(negedge clk);
        check("wr_ready", 64'(pipe_wr_ready), 64'(1));
        check("wr_en", 64'(csr_wr_en), 64'(1));
        check("wr_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        pipe_wr_valid = 1'b0; pipe_raddr = CSR_SAVE0;
        @(negedge clk);
        check("rd_save0", 64'(pipe_rdata), 64'(32'hdead_beef));
        check("q_empty_wr", 64'(exp_q.size()), 64'(0));

        // trap with BADV: CRMD=7 -> PRMD=7, CRMD PLV/IE cleared -> 0
        preload(CSR_CRMD, 32'h0000_0007);
        preload(CSR_ESTAT, 32'hffff_1234);
        preload(CSR_EENTRY, 32'h1c00_8000);
        expect_wr(CSR_PRMD, 32'h0000_0007);
        expect_wr(CSR_CRMD, 32'h0000_0000);
        expect_wr(CSR_ERA, 32'h1c00_0abc);
        expect_wr(CSR_ESTAT, 32'he943_1234);
        expect_wr(CSR_BADV, 32'h0000_1234);
        drive_trap(6'h03, 9'h1a5, 32'h1c00_0abc, 32'h0000_1234, 1'b1, 1'b0);
        wait_redirect(cyc);
        check("t1_cycles", 64'(cyc), 64'(7));
        check("t1_redir_pc", 64'(redirect_pc), 64'(32'h1c00_8000));
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_q_empty", 64'(exp_q.size()), 64'(0));

        // trap without BADV; EENTRY low bits are masked
        preload(CSR_CRMD, 32'h0000_001e);
        preload(CSR_ESTAT, 32'h0000_abcd);
        preload(CSR_EENTRY, 32'h1c00_807f);
        expect_wr(CSR_PRMD, 32'h0000_0006);
        expect_wr(CSR_CRMD, 32'h0000_0018);
        expect_wr(CSR_ERA, 32'h1c00_0200);
        expect_wr(CSR_ESTAT, 32'h004c_abcd);
        drive_trap(6'h0c, 9'h001, 32'h1c00_0200, 32'hbad0_bad0, 1'b0, 1'b0);
        wait_redirect(cyc);
        check("t2_cycles", 64'(cyc), 64'(6));
        check("t2_redir_pc", 64'(redirect_pc), 64'(32'h1c00_8040));
        check("t2_q_empty", 64'(exp_q.size()), 64'(0));

        // ERTN: CRMD 0x8 with PRMD 0x6 restores to 0xe
        preload(CSR_PRMD, 32'h0000_0006);
        preload(CSR_CRMD, 32'h0000_0008);
        preload(CSR_ERA, 32'h1c00_0100);
        expect_wr(CSR_CRMD, 32'h0000_000e);
        @(posedge clk); #1;
        ertn_valid = 1'b1;
        @(negedge clk);
        check("ertn_ready", 64'(pipe_wr_ready), 64'(0));
        @(posedge clk); #1;
        ertn_valid = 1'b0;
        wait_redirect(cyc);
        check("ertn_cycles", 64'(cyc), 64'(4));
        check("ertn_redir_pc", 64'(redirect_pc), 64'(32'h1c00_0100));
        @(posedge clk); #1;
        pipe_raddr = CSR_CRMD;
        @(negedge clk);
        check("ertn_crmd", 64'(pipe_rdata), 64'(32'h0000_000e));
        check("ertn_q_empty", 64'(exp_q.size()), 64'(0));

        // excp + ertn + csrwr together: exception wins, csrwr held off throughout
        preload(CSR_CRMD, 32'h0000_0003);
        preload(CSR_ESTAT, 32'h8000_0000);
        preload(CSR_EENTRY, 32'h1c00_8000);
        expect_wr(CSR_PRMD, 32'h0000_0003);
        expect_wr(CSR_CRMD, 32'h0000_0000);
        expect_wr(CSR_ERA, 32'h1c00_0300);
        expect_wr(CSR_ESTAT, 32'hffff_0000);
        expect_wr(CSR_BADV, 32'hcafe_0000);
        drive_trap(6'h3f, 9'h1ff, 32'h1c00_0300, 32'hcafe_0000, 1'b1, 1'b1);
        wait_redirect(cyc);
        check("combo_cycles", 64'(cyc), 64'(7));
        check("combo_redir_pc", 64'(redirect_pc), 64'(32'h1c00_8000));
        check("combo_busy_ready", 64'(pipe_wr_ready), 64'(0));
        @(posedge clk); #1;
        pipe_wr_valid = 1'b0;
        check("combo_q_empty", 64'(exp_q.size()), 64'(0));

        // reset in X_WR_ERA: PRMD/CRMD done, nothing after
        preload(CSR_CRMD, 32'h0000_0005);
        expect_wr(CSR_PRMD, 32'h0000_0005);
        expect_wr(CSR_CRMD, 32'h0000_0000);
        drive_trap(6'h01, 9'h000, 32'h1c00_0400, 32'h0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_state", 64'(dbg_state), 64'(S_X_WR_ERA));
        check("rstmid_wr_en", 64'(csr_wr_en), 64'(0));
        redir_seen = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_idle", 64'(dbg_state), 64'(S_IDLE));
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rstmid_no_redir", 64'(redir_seen), 64'(0));
        check("rstmid_q_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
